wb_dma_copy: RTL and testbench
==============================

Name: wb_dma_copy

Overview:
- Wishbone initiator (bus master) that copies a block of 32-bit words from a source address range to a destination address range.
- Connects as an additional master port on the system interconnect, alongside the CPU instruction and data masters, and targets the same RAM, ROM and UART slave windows.
- Driven by a simple start/length command interface; reports busy, done and error status.
- Bus protocol is classic single-beat Wishbone: one outstanding access, no bursts.

Parameters:
WB_ADDR_WIDTH, 32, width of bus address and of the src/dst command inputs
WB_DATA_WIDTH, 32, bus data width; only 32 is supported
LEN_WIDTH, 16, width of the word-count input
TIMEOUT, 255, max cycles a single access may wait for ack/err before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  single-cycle command strobe; sampled only in IDLE
src_i  in  WB_ADDR_WIDTH  source byte address; bits [1:0] ignored (treated as 0)
dst_i  in  WB_ADDR_WIDTH  destination byte address; bits [1:0] ignored
len_i  in  LEN_WIDTH  number of words to copy
abort_i  in  1  request to stop the transfer at the next access boundary
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse at end of transfer (normal, error or abort)
err_o  out  1  sticky: last transfer ended on bus error or timeout; cleared by an accepted start
words_o  out  LEN_WIDTH  count of words fully written in the current/last transfer
m_adr  out  WB_ADDR_WIDTH  bus address
m_dat_w  out  WB_DATA_WIDTH  write data
m_dat_r  in  WB_DATA_WIDTH  read data
m_cyc  out  1  bus cycle
m_stb  out  1  strobe
m_we  out  1  write enable
m_sel  out  4  byte selects; always 4'hF when m_stb=1, else 0
m_ack  in  1  slave acknowledge
m_err  in  1  slave error

Behaviour:
- Reset (async, active-high): state=IDLE. busy_o, done_o, err_o, m_cyc, m_stb, m_we = 0; m_adr, m_dat_w, m_sel, words_o = 0. All bus outputs drop immediately, including mid-transfer; the transfer is not resumed.
- All outputs are registered. m_cyc equals m_stb at all times.
- FSM states: IDLE, RD, RGAP, WR, WGAP.
- IDLE:
  - start_i=1 with len_i!=0: latch src/dst with bits [1:0] forced to 0, latch len; clear err_o and words_o; busy_o=1; go to RD.
  - start_i=1 with len_i=0: done_o pulses next cycle; no bus activity; busy_o stays 0; err_o cleared.
- RD: m_cyc=m_stb=1, m_we=0, m_adr=src+4*i.
  - On m_ack: capture m_dat_r; go to RGAP.
- RGAP: stb/cyc=0 for exactly one cycle; go to WR.
- WR: m_cyc=m_stb=1, m_we=1, m_adr=dst+4*i, m_dat_w=captured word.
  - On m_ack: words_o+1; go to WGAP.
- WGAP: stb/cyc=0.
  - If words_o==len or abort is pending: done_o=1, busy_o=0, go to IDLE.
  - Otherwise i+1, go to RD.
- Bus timing: bus outputs change only on the cycle after an ack/err, never while stb is waiting.
- Each word costs at least 4 cycles with a zero-wait combinational-ack slave.
- m_err in RD or WR: drop stb/cyc next cycle; err_o=1, done_o=1, busy_o=0; go to IDLE. words_o excludes the failing word.
- m_ack and m_err asserted together: treated as error.
- Watchdog: a counter resets on each stb assertion. If TIMEOUT!=0 and stb has been held TIMEOUT cycles with no ack/err, the access is handled exactly as m_err.
- abort_i:
  - Latched as pending while busy.
  - An in-flight access always completes; the transfer ends at the next WGAP.
  - An abort pending during RD/RGAP still finishes that word's write.
  - Abort does not set err_o.
- start_i while busy: ignored.
- Address arithmetic: modulo 2^WB_ADDR_WIDTH; wrap from 0xFFFF_FFFC to 0 is silent.
- Source and destination ranges may overlap: copy is forward, word by word, with no overlap correction.

Test Plan:
- Basic copy: slave with 1-cycle registered ack; src=0x1000_0000, dst=0x1000_0100, len=4, RAM preloaded 0x11111111..0x44444444 -> dst words match; 4 reads then 4 writes interleaved R,W,R,W; done_o one pulse; words_o=4; err_o=0; m_sel=4'hF on every beat.
- len=0 and unaligned addresses: len=0 -> done_o pulse 1 cycle after start, m_cyc never high. src=0x1000_0003, len=1 -> first read adr=0x1000_0000.
- Bus error: m_err on the 3rd read of len=8 -> err_o=1, words_o=2, m_cyc low the next cycle, done_o pulse; a new accepted start clears err_o.
- Timeout: TIMEOUT=16, slave never acks at 0x8000_2000 (unmapped) -> stb high exactly 16 cycles, then err_o=1, done_o pulse, busy_o=0.
- Abort and ignored start: abort_i during the 2nd read of len=10 -> 2 words written, done_o, err_o=0. start_i pulsed while busy -> no effect on src/len.
- Reset mid-write: rst asserted while m_stb=1 in WR -> m_cyc/m_stb/busy_o low in the same cycle (async). After release, FSM in IDLE, words_o=0.

Source files
------------

// File: rtl/wb_dma_copy.sv
// Wishbone block-copy master: each word is a single-beat read then a single-beat write, four cycles per word at best.
// One outstanding access; slave wait states stall the copy, and a watchdog turns a hung access into a bus error.
module wb_dma_copy #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [WB_ADDR_WIDTH-1:0] src_i,
  input  logic [WB_ADDR_WIDTH-1:0] dst_i,
  input  logic [LEN_WIDTH-1:0]     len_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [LEN_WIDTH-1:0]     words_o,
  output logic [WB_ADDR_WIDTH-1:0] m_adr,
  output logic [WB_DATA_WIDTH-1:0] m_dat_w,
  input  logic [WB_DATA_WIDTH-1:0] m_dat_r,
  output logic                     m_cyc,
  output logic                     m_stb,
  output logic                     m_we,
  output logic [3:0]               m_sel,
  input  logic                     m_ack,
  input  logic                     m_err
);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP} state_t;

  state_t                   state_q;
  logic [AW-1:0]            src_q, dst_q, adr_q;
  logic [LEN_WIDTH-1:0]     len_q, words_q;
  logic [WB_DATA_WIDTH-1:0] data_q, dat_w_q;
  logic [TW-1:0]            wd_q;
  logic                     stb_q, we_q, busy_q, done_q, err_q, abort_q;

  logic          wd_fire_d, bus_ok_d, bus_fail_d, abort_pend_d, last_word_d;
  logic [AW-1:0] src_al_d, dst_al_d;
  logic          unused_addr_bits;

  assign src_al_d         = {src_i[AW-1:2], 2'b00};
  assign dst_al_d         = {dst_i[AW-1:2], 2'b00};
  assign unused_addr_bits = ^{src_i[1:0], dst_i[1:0]};

  // An ack arriving on the watchdog's last cycle still wins over the timeout.
  assign wd_fire_d    = (TIMEOUT != 0) && (wd_q == TO_LAST);
  assign bus_fail_d   = m_err || (!m_ack && wd_fire_d);
  assign bus_ok_d     = m_ack && !m_err;
  assign abort_pend_d = abort_q || abort_i;
  assign last_word_d  = (words_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      adr_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      dat_w_q <= '0;
      wd_q    <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && abort_i) abort_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            err_q   <= 1'b0;
            words_q <= '0;
            abort_q <= 1'b0;
            if (len_i != '0) begin
              src_q   <= src_al_d;
              dst_q   <= dst_al_d;
              len_q   <= len_i;
              busy_q  <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b0;
              adr_q   <= src_al_d;
              wd_q    <= '0;
              state_q <= RD;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RD, WR: begin
          if (bus_fail_d) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bus_ok_d) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (state_q == RD) begin
              data_q  <= m_dat_r;
              src_q   <= src_q + AW'(4);
              state_q <= RGAP;
            end else begin
              words_q <= words_q + 1'b1;
              dst_q   <= dst_q + AW'(4);
              state_q <= WGAP;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RGAP: begin
          stb_q   <= 1'b1;
          we_q    <= 1'b1;
          adr_q   <= dst_q;
          dat_w_q <= data_q;
          wd_q    <= '0;
          state_q <= WR;
        end
        WGAP: begin
          // Abort is only honoured here, so a read already issued always gets its write.
          if (last_word_d || abort_pend_d) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= src_q;
            wd_q    <= '0;
            state_q <= RD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign words_o = words_q;
  assign m_adr   = adr_q;
  assign m_dat_w = dat_w_q;
  assign m_cyc   = stb_q;
  assign m_stb   = stb_q;
  assign m_we    = we_q;
  assign m_sel   = {4{stb_q}};
endmodule

// File: tb/tb_wb_dma_copy.sv
// Bench for wb_dma_copy: wait-state/error-injecting slave, bus monitor, and a word-level copy model.
// Directed scenarios plus randomized copies, each compared against the model's trace and memory image.
module tb_wb_dma_copy;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, abort_i;
  logic [31:0] src_i, dst_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] words_o;
  logic [31:0] m_adr, m_dat_w, m_dat_r;
  logic        m_cyc, m_stb, m_we, m_ack, m_err;
  logic [3:0]  m_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_dma_copy #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_i(src_i), .dst_i(dst_i),
    .len_i(len_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .words_o(words_o), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_sel(m_sel), .m_ack(m_ack), .m_err(m_err)
  );

  // Slave memory: 1024 words mirrored across every mapped window; 0x8xxx_xxxx never answers.
  bit [31:0]   smem  [1024];
  bit          sflag [1024];
  bit [31:0]   rmem  [1024];
  bit          rflag [1024];
  logic        s_ack, s_err;
  logic [31:0] s_rdat;
  int          s_wcnt;
  int          s_rd_cnt = 0;
  int          lat = 0;
  int          err_rd_abs = 0;

  assign m_ack   = s_ack;
  assign m_err   = s_err;
  assign m_dat_r = s_rdat;

  function automatic int unsigned widx(input logic [31:0] a);
    return {22'd0, a[11:2]};
  endfunction

  function automatic logic [31:0] bg(input int unsigned i);
    if (i < 4) return (i + 1) * 32'h1111_1111;
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] sread(input logic [31:0] a);
    return sflag[widx(a)] ? smem[widx(a)] : bg(widx(a));
  endfunction

  function automatic logic [31:0] rread(input logic [31:0] a);
    return rflag[widx(a)] ? rmem[widx(a)] : bg(widx(a));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_err  <= 1'b0;
      s_wcnt <= 0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (m_stb && (s_ack || s_err)) begin
        if (m_we && s_ack && !s_err) begin
          smem[widx(m_adr)]  <= m_dat_w;
          sflag[widx(m_adr)] <= 1'b1;
        end
      end else if (m_stb && m_adr[31:28] != 4'h8) begin
        if (s_wcnt < lat) begin
          s_wcnt <= s_wcnt + 1;
        end else begin
          s_wcnt <= 0;
          if (!m_we) begin
            s_rd_cnt <= s_rd_cnt + 1;
            s_rdat   <= sread(m_adr);
            if (s_rd_cnt + 1 == err_rd_abs) s_err <= 1'b1;
            else                            s_ack <= 1'b1;
          end else begin
            s_ack <= 1'b1;
          end
        end
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  beat_t       trace [$];
  beat_t       exp_q [$];
  int          viol = 0, run = 0, last_run = 0, stb_cycles = 0;
  logic        prev_stb = 1'b0, prev_resp = 1'b0, prev_we = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  always @(negedge clk) begin
    viol <= viol
          + int'(m_cyc !== m_stb)
          + int'(m_sel !== (m_stb ? 4'hF : 4'h0))
          + int'(m_stb && prev_stb && !prev_resp &&
                 (m_adr !== prev_adr || m_we !== prev_we || (m_we && m_dat_w !== prev_dat)))
          + int'(done_o === 1'b1 && prev_done === 1'b1);
    if (m_stb && m_ack && !m_err)
      trace.push_back('{m_we, m_adr, (m_we ? m_dat_w : m_dat_r)});
    if (m_stb) begin
      run        <= run + 1;
      stb_cycles <= stb_cycles + 1;
    end else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
    prev_stb  <= m_stb;
    prev_resp <= m_ack || m_err;
    prev_we   <= m_we;
    prev_adr  <= m_adr;
    prev_dat  <= m_dat_w;
    prev_done <= done_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level copy semantics: forward, one word at a time, 32-bit address wrap.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] ra, wa, v;
    s = s & ~32'h3;
    d = d & ~32'h3;
    for (int i = 0; i < n; i++) begin
      ra = s + 32'(4 * i);
      wa = d + 32'(4 * i);
      v  = rread(ra);
      exp_q.push_back('{1'b0, ra, v});
      rmem[widx(wa)]  = v;
      rflag[widx(wa)] = 1'b1;
      exp_q.push_back('{1'b1, wa, v});
    end
  endtask

  task automatic check_trace(input string tag, input int t0);
    int mism = 0;
    chk({tag, "_beats"}, trace.size() - t0, exp_q.size());
    for (int i = 0; i < exp_q.size() && t0 + i < trace.size(); i++)
      if (trace[t0 + i] !== exp_q[i]) mism++;
    chk({tag, "_trace"}, mism, 0);
    exp_q.delete();
  endtask

  task automatic check_mem(input string tag);
    int mism = 0;
    for (int i = 0; i < 1024; i++)
      if ((sflag[i] ? smem[i] : bg(i)) !== (rflag[i] ? rmem[i] : bg(i))) mism++;
    chk(tag, mism, 0);
  endtask

  task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    src_i   = s;
    dst_i   = d;
    len_i   = l;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_o !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done_o, 1'b1);
  endtask

  task automatic check_done(input string tag, input logic exp_err, input int exp_words);
    chk({tag, "_busy_at_done"}, busy_o, 1'b0);
    chk({tag, "_cyc_at_done"}, m_cyc, 1'b0);
    chk({tag, "_err"}, err_o, exp_err);
    chk({tag, "_words"}, words_o, exp_words[15:0]);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done_o, 1'b0);
  endtask

  initial begin
    logic [31:0] s, d;
    int          l, t0, n, sc0;
    beat_t       b;

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    src_i = '0; dst_i = '0; len_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_status", {busy_o, done_o, err_o, words_o}, 0);
    chk("rst_bus", {m_cyc, m_stb, m_we, m_sel, m_adr}, 0);
    chk("rst_wdat", m_dat_w, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic copy of the preloaded 0x11111111..0x44444444 block.
    lat = 0;
    t0 = trace.size();
    start_cmd(32'h1000_0000, 32'h1000_0100, 16'd4);
    chk("basic_busy", busy_o, 1'b1);
    wait_done("basic");
    check_done("basic", 1'b0, 4);
    model_copy(32'h1000_0000, 32'h1000_0100, 4);
    check_trace("basic", t0);
    chk("basic_last_word", sread(32'h1000_010C), 32'h4444_4444);

    // Zero length: done next cycle, no bus traffic.
    sc0 = stb_cycles;
    start_cmd(32'h1000_0000, 32'h1000_0200, 16'd0);
    chk("len0_done", done_o, 1'b1);
    chk("len0_busy", busy_o, 1'b0);
    @(negedge clk);
    chk("len0_done_one_cycle", done_o, 1'b0);
    chk("len0_no_bus", stb_cycles, sc0);

    // Unaligned addresses are truncated to word boundaries.
    t0 = trace.size();
    start_cmd(32'h1000_0003, 32'h1000_0202, 16'd1);
    wait_done("unal");
    check_done("unal", 1'b0, 1);
    b = (trace.size() > t0) ? trace[t0] : '0;
    chk("unal_first_rd_adr", b.adr, 32'h1000_0000);
    model_copy(32'h1000_0003, 32'h1000_0202, 1);
    check_trace("unal", t0);

    // Bus error on the third read.
    t0 = trace.size();
    err_rd_abs = s_rd_cnt + 3;
    start_cmd(32'h1000_0010, 32'h1000_0300, 16'd8);
    wait_done("berr");
    check_done("berr", 1'b1, 2);
    err_rd_abs = 0;
    model_copy(32'h1000_0010, 32'h1000_0300, 2);
    check_trace("berr", t0);
    chk("berr_sticky", err_o, 1'b1);
    t0 = trace.size();
    start_cmd(32'h1000_0020, 32'h1000_0320, 16'd1);
    chk("berr_cleared_by_start", err_o, 1'b0);
    wait_done("after_err");
    check_done("after_err", 1'b0, 1);
    model_copy(32'h1000_0020, 32'h1000_0320, 1);
    check_trace("after_err", t0);

    // Watchdog on an unmapped source.
    start_cmd(32'h8000_2000, 32'h1000_0400, 16'd2);
    wait_done("tmo");
    check_done("tmo", 1'b1, 0);
    chk("tmo_stb_cycles", last_run, 16);

    // Abort raised during the second read.
    lat = 1;
    t0 = trace.size();
    s = 32'h1000_0500;
    start_cmd(s, 32'h1000_0600, 16'd10);
    n = 0;
    while (!(m_stb && !m_we && m_adr == s + 32'd4) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_rd2", n < 2000, 1'b1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    wait_done("abort");
    check_done("abort", 1'b0, 2);
    model_copy(s, 32'h1000_0600, 2);
    check_trace("abort", t0);

    // Start while busy is ignored.
    lat = 0;
    t0 = trace.size();
    start_cmd(32'h1000_0700, 32'h1000_0780, 16'd4);
    repeat (3) @(negedge clk);
    src_i = 32'h1000_0000; dst_i = 32'h1000_0900; len_i = 16'd1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("busy_start");
    check_done("busy_start", 1'b0, 4);
    model_copy(32'h1000_0700, 32'h1000_0780, 4);
    check_trace("busy_start", t0);

    // Source wraps past the top of the address space.
    t0 = trace.size();
    start_cmd(32'hFFFF_FFF8, 32'h1000_0A00, 16'd3);
    wait_done("wrap");
    check_done("wrap", 1'b0, 3);
    model_copy(32'hFFFF_FFF8, 32'h1000_0A00, 3);
    check_trace("wrap", t0);

    // Overlapping forward copy smears the first word.
    t0 = trace.size();
    start_cmd(32'h1000_0B00, 32'h1000_0B04, 16'd4);
    wait_done("ovl");
    check_done("ovl", 1'b0, 4);
    model_copy(32'h1000_0B00, 32'h1000_0B04, 4);
    check_trace("ovl", t0);
    chk("ovl_smear", sread(32'h1000_0B10), rread(32'h1000_0B00));

    for (int k = 0; k < 6; k++) begin
      lat = $urandom_range(0, 2);
      s   = 32'h1000_0000 + 32'($urandom_range(0, 1023) * 4);
      d   = 32'h1000_0000 + 32'($urandom_range(0, 1023) * 4);
      l   = $urandom_range(1, 6);
      t0  = trace.size();
      start_cmd(s, d, l[15:0]);
      wait_done("rnd");
      check_done("rnd", 1'b0, l);
      model_copy(s, d, l);
      check_trace("rnd", t0);
    end

    // Async reset while the second write is waiting for its ack.
    lat = 2;
    t0 = trace.size();
    s = 32'h1000_0C00;
    start_cmd(s, 32'h1000_0D00, 16'd3);
    n = 0;
    while (!(m_stb && m_we && words_o == 16'd1 && !m_ack) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_reached_wr2", n < 2000, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_bus_low", {m_cyc, m_stb, busy_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", {busy_o, done_o, words_o}, 0);
    model_copy(s, 32'h1000_0D00, 1);
    exp_q.push_back('{1'b0, s + 32'd4, rread(s + 32'd4)});
    check_trace("rstmid", t0);
    lat = 0;
    t0 = trace.size();
    start_cmd(32'h1000_0E00, 32'h1000_0E80, 16'd2);
    wait_done("post_rst");
    check_done("post_rst", 1'b0, 2);
    model_copy(32'h1000_0E00, 32'h1000_0E80, 2);
    check_trace("post_rst", t0);

    check_mem("final_mem");
    @(negedge clk);
    chk("protocol_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
